// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank feeding Simulink user logic in the OPB_Clk domain.
// Holds C_NUM_REGS 32-bit registers with byte-enable writes, readback and an
// optional shadow/commit scheme so several outputs change in the same cycle.
// Ports:
//   OPB_Clk, OPB_Rst            clock, async active-high reset
//   OPB_ABus/BE/DBus/RNW/select OPB master request (OPB bit 0 = MSB)
//   OPB_seqAddr                 unused
//   Sl_DBus, Sl_xferAck         read data (zero outside ack) and acknowledge
//   Sl_errAck/retry/toutSup     tied low
//   user_data_out               register i at bits [32i+31:32i]
//   user_update, user_commit    one-cycle load pulses aligned with new outputs
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000100,
    parameter logic [31:0] C_HIGHADDR    = 32'h010001FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_SHADOW_MODE = 1,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_update,
    output logic                      user_commit
);

    localparam logic [31:0] NR32 = C_NUM_REGS;

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state_q;
    logic [31:0]           shadow_q [C_NUM_REGS];
    logic [31:0]           out_q    [C_NUM_REGS];
    logic [15:0]           commit_q;
    logic                  xfer_ack_q;
    logic [31:0]           dbus_q;
    logic [C_NUM_REGS-1:0] update_q;
    logic                  commit_pulse_q;

    // Big-endian OPB vectors land MSB-first, so OPB bit k becomes bit 31-k.
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] idx;
    logic        hit;
    logic        is_data;
    logic        is_ctrl;
    logic        do_commit;
    logic [31:0] rd_data;
    logic        unused;

    assign addr    = OPB_ABus;
    assign wdata   = OPB_DBus;
    assign be      = OPB_BE;
    assign idx     = (addr - C_BASEADDR) >> 2;
    assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign is_data = idx < NR32;
    assign is_ctrl = idx == NR32;
    assign unused  = OPB_seqAddr;

    // Commit bit is register bit 0, carried in byte lane 3.
    assign do_commit = is_ctrl && (C_SHADOW_MODE != 0) && be[0] && wdata[0];

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  mask
    );
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = mask[j] ? new_v[8*j +: 8] : old_v[8*j +: 8];
        end
        return r;
    endfunction

    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data = {16'h0, commit_q};
        end
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == 32'(i)) begin
                rd_data = (C_SHADOW_MODE != 0) ? shadow_q[i] : out_q[i];
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q        <= IDLE;
            xfer_ack_q     <= 1'b0;
            dbus_q         <= '0;
            update_q       <= '0;
            commit_pulse_q <= 1'b0;
            commit_q       <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_q[i] <= C_RESET_VALUE;
                out_q[i]    <= C_RESET_VALUE;
            end
        end else begin
            xfer_ack_q     <= 1'b0;
            dbus_q         <= '0;
            update_q       <= '0;
            commit_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q    <= ACK;
                        xfer_ack_q <= 1'b1;
                        if (OPB_RNW) begin
                            dbus_q <= rd_data;
                        end else begin
                            for (int i = 0; i < C_NUM_REGS; i++) begin
                                if (idx == 32'(i)) begin
                                    if (C_SHADOW_MODE != 0) begin
                                        shadow_q[i] <= merge(shadow_q[i], wdata, be);
                                    end else begin
                                        out_q[i]    <= merge(out_q[i], wdata, be);
                                        update_q[i] <= 1'b1;
                                    end
                                end
                            end
                            if (do_commit) begin
                                for (int i = 0; i < C_NUM_REGS; i++) begin
                                    out_q[i] <= shadow_q[i];
                                end
                                update_q       <= '1;
                                commit_pulse_q <= 1'b1;
                                commit_q       <= commit_q + 16'd1;
                            end
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = out_q[g];
    end

    assign Sl_DBus     = dbus_q;
    assign Sl_xferAck  = xfer_ack_q;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_update = update_q;
    assign user_commit = commit_pulse_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink: one shadow-mode and one
// direct-mode instance share the OPB request lines but have separate selects.
module tb_opb_register_bank_ppc2simulink;

    logic         clk;
    logic         rst;
    logic [0:31]  abus;
    logic [0:3]   be;
    logic [0:31]  dbus;
    logic         rnw;
    logic         sel0;
    logic         sel1;
    logic         seq;

    logic [0:31]  rd0, rd1;
    logic         ack0, ack1;
    logic         err0, err1, rty0, rty1, tos0, tos1;
    logic [127:0] udo0, udo1;
    logic [3:0]   upd0, upd1;
    logic         cmt0, cmt1;

    int checks;
    int failures;

    opb_register_bank_ppc2simulink #(.C_SHADOW_MODE(1)) u1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel1),
        .OPB_seqAddr(seq), .Sl_DBus(rd1), .Sl_xferAck(ack1),
        .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tos1),
        .user_data_out(udo1), .user_update(upd1), .user_commit(cmt1)
    );

    opb_register_bank_ppc2simulink #(.C_SHADOW_MODE(0)) u0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel0),
        .OPB_seqAddr(seq), .Sl_DBus(rd0), .Sl_xferAck(ack0),
        .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tos0),
        .user_data_out(udo0), .user_update(upd0), .user_commit(cmt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer; outputs are sampled 1ns into the cycle after the hit edge
    // (the ack cycle), then one more cycle lets the slave return to IDLE.
    task automatic xfer(input bit tgt0, input logic [31:0] a, input logic r,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic ack, output logic [31:0] rd,
                        output logic [3:0] upd, output logic cmt,
                        output logic [127:0] udo);
        @(negedge clk);
        abus = a; rnw = r; dbus = d; be = m;
        if (tgt0) sel0 = 1'b1; else sel1 = 1'b1;
        @(posedge clk); #1;
        sel0 = 1'b0; sel1 = 1'b0;
        ack = tgt0 ? ack0 : ack1;
        rd  = tgt0 ? rd0  : rd1;
        upd = tgt0 ? upd0 : upd1;
        cmt = tgt0 ? cmt0 : cmt1;
        udo = tgt0 ? udo0 : udo1;
        @(posedge clk); #1;
    endtask

    logic         a_o;
    logic [31:0]  d_o;
    logic [3:0]   u_o;
    logic         c_o;
    logic [127:0] q_o;
    logic [31:0]  b2b_addr [4];
    logic [31:0]  b2b_exp  [3];

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0;
        sel0 = 1'b0; sel1 = 1'b0; seq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_udo1", udo1, 128'h0);
        check("rst_udo0", udo0, 128'h0);
        check("rst_ack1", {127'h0, ack1}, 128'h0);
        check("rst_dbus1", {96'h0, rd1}, 128'h0);
        check("rst_upd", {120'h0, upd1, upd0}, 128'h0);
        check("rst_ties", {122'h0, err0, err1, rty0, rty1, tos0, tos1}, 128'h0);
        rst = 1'b0;

        // Shadow writes do not reach the outputs.
        xfer(0, 32'h01000100, 0, 32'hDEADBEEF, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("wr0_ack", {127'h0, a_o}, 128'h1);
        check("wr0_upd", {124'h0, u_o}, 128'h0);
        xfer(0, 32'h01000104, 0, 32'h12345678, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("wr1_noout", udo1, 128'h0);
        xfer(0, 32'h01000100, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("rd0", {96'h0, d_o}, {96'h0, 32'hDEADBEEF});
        xfer(0, 32'h01000104, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("rd1", {96'h0, d_o}, {96'h0, 32'h12345678});
        check("rd1_after_dbus0", {96'h0, rd1}, 128'h0);

        // Commit.
        xfer(0, 32'h01000110, 0, 32'h1, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("cmt_udo", q_o, {64'h0, 32'h12345678, 32'hDEADBEEF});
        check("cmt_upd", {124'h0, u_o}, {124'h0, 4'b1111});
        check("cmt_pulse", {127'h0, c_o}, 128'h1);
        check("cmt_after", {123'h0, cmt1, upd1}, 128'h0);
        xfer(0, 32'h01000110, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("ctrl_rd1", {96'h0, d_o}, 128'h1);

        // Byte enables: lanes 1 and 3 only.
        xfer(0, 32'h01000100, 0, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        xfer(0, 32'h01000100, 0, 32'hAABBCCDD, 4'b0101, a_o, d_o, u_o, c_o, q_o);
        xfer(0, 32'h01000100, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("be_rd", {96'h0, d_o}, {96'h0, 32'h00BB00DD});

        // Direct mode.
        xfer(1, 32'h01000108, 0, 32'hCAFEF00D, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("m0_udo", q_o, {32'h0, 32'hCAFEF00D, 64'h0});
        check("m0_upd", {124'h0, u_o}, {124'h0, 4'b0100});
        check("m0_upd_after", {124'h0, upd0}, 128'h0);
        xfer(1, 32'h01000108, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("m0_rd", {96'h0, d_o}, {96'h0, 32'hCAFEF00D});
        xfer(1, 32'h01000110, 0, 32'h1, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("m0_ctrl_wr", {123'h0, c_o, u_o}, 128'h0);
        xfer(1, 32'h01000110, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("m0_ctrl_rd", {95'h0, a_o, d_o}, {95'h0, 1'b1, 32'h0});

        // Reserved index and out-of-window address.
        xfer(0, 32'h01000114, 0, 32'hFFFFFFFF, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("rsv_wr_ack", {127'h0, a_o}, 128'h1);
        xfer(0, 32'h01000114, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("rsv_rd", {95'h0, a_o, d_o}, {95'h0, 1'b1, 32'h0});
        xfer(0, 32'h01000200, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("oor_noack", {127'h0, a_o}, 128'h0);
        xfer(0, 32'h01000200, 0, 32'h55555555, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("oor_wr_noack", {127'h0, a_o}, 128'h0);
        xfer(0, 32'h01000104, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("oor_nochange", {96'h0, d_o}, {96'h0, 32'h12345678});

        // Counter wrap: preload one short of wrap instead of 65535 commits.
        @(negedge clk);
        force u1.commit_q = 16'hFFFF;
        @(negedge clk);
        release u1.commit_q;
        xfer(0, 32'h01000110, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("cnt_max", {96'h0, d_o}, {96'h0, 32'h0000FFFF});
        xfer(0, 32'h01000110, 0, 32'h1, 4'b0001, a_o, d_o, u_o, c_o, q_o);
        check("cnt_wrap_pulse", {127'h0, c_o}, 128'h1);
        xfer(0, 32'h01000110, 1, 32'h0, 4'hF, a_o, d_o, u_o, c_o, q_o);
        check("cnt_wrap", {96'h0, d_o}, 128'h0);

        // Back-to-back reads with select held.
        b2b_addr[0] = 32'h01000100; b2b_addr[1] = 32'h01000104;
        b2b_addr[2] = 32'h01000100; b2b_addr[3] = 32'h01000104;
        b2b_exp[0] = 32'h00BB00DD; b2b_exp[1] = 32'h12345678;
        b2b_exp[2] = 32'h00BB00DD;
        @(negedge clk);
        abus = b2b_addr[0]; rnw = 1'b1; be = 4'hF; sel1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                check("b2b_ack", {95'h0, ack1, rd1},
                      {95'h0, 1'b1, b2b_exp[k/2]});
                abus = b2b_addr[k/2 + 1];
            end else begin
                check("b2b_gap", {95'h0, ack1, rd1}, 128'h0);
            end
        end
        sel1 = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of an ack cycle.
        @(negedge clk);
        abus = 32'h01000100; rnw = 1'b0; dbus = 32'h11111111; be = 4'hF;
        sel0 = 1'b1;
        @(posedge clk); #1;
        sel0 = 1'b0;
        check("mid_ack_pre", {127'h0, ack0}, 128'h1);
        rst = 1'b1;
        #1;
        check("mid_ack_drop", {127'h0, ack0}, 128'h0);
        check("mid_rst_udo", udo0, 128'h0);
        check("mid_rst_upd", {124'h0, upd0}, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_noack", {127'h0, ack0}, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised OPB slave register bank; generalises the single software-to-fabric register to C_NUM_REGS 32-bit registers.
- Supports byte-enable writes, readback, and an optional shadow/commit mode so several registers update the fabric atomically.
- Sits on the PPC OPB bus; outputs feed Simulink user logic in the OPB_Clk domain.
- Single clock; no clock-domain crossing inside.

Parameters:
- C_BASEADDR, 32'h01000100, first byte address of the window.
- C_HIGHADDR, 32'h010001FF, last byte address of the window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (only 32 is supported).
- C_NUM_REGS, 4, number of data registers (1..32). Requires (C_NUM_REGS+1)*4 <= window size.
- C_SHADOW_MODE, 1. 0 = a write updates the output directly; 1 = a write updates a shadow, and a commit copies all shadows to the outputs.
- C_RESET_VALUE, 32'h00000000, reset value of every shadow and output register.

Ports:
- OPB_Clk  in  1  bus and user clock.
- OPB_Rst  in  1  asynchronous, active-high reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_out  out  [C_NUM_REGS*32-1:0]  register i at bits [32i+31:32i].
- user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse per output register that was loaded.
- user_commit  out  1  one-cycle pulse on commit (shadow mode only; 0 otherwise).

Behaviour:
- Reset (async, OPB_Rst=1):
  - Shadows and outputs = C_RESET_VALUE.
  - Sl_xferAck=0, Sl_DBus=0, user_update=0, user_commit=0, commit_count=0, FSM=IDLE.
  - Reset asserted mid-transfer aborts it; no ack is issued.
- Decode:
  - hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
  - idx = (OPB_ABus - C_BASEADDR) >> 2.
  - idx < C_NUM_REGS selects a data register; idx == C_NUM_REGS selects the control register; higher idx is reserved.
- Bit order: OPB bit k maps to register bit 31-k, e.g. DBus[31] is register bit 0.
- FSM with states IDLE and ACK:
  - IDLE -> ACK when hit is sampled high. The write or read capture happens on that edge.
  - ACK drives Sl_xferAck=1 for exactly one cycle. On reads, Sl_DBus carries the data only during that cycle.
  - ACK -> IDLE unconditionally.
  - From IDLE, a new transfer is accepted on the next hit, so back-to-back transfers with select held give an ack every 2nd cycle.
  - Ack latency: 1 cycle after select is first sampled.
- Sl_DBus is 0 whenever Sl_xferAck=0 (OR-bus requirement).
- Data write: for each b with BE[b]=1, byte b of the target is updated.
  - Target is the shadow if C_SHADOW_MODE=1, else the output register.
  - Mode 0: user_update[idx] pulses in the cycle the output changes, which is the ACK cycle. The pulse fires even if the value is unchanged.
- Data read returns the shadow (mode 1) or the output (mode 0).
- Control write with BE[3]=1 and DBus[31]=1 in mode 1 triggers a commit:
  - All outputs load from their shadows.
  - user_update = all ones and user_commit = 1 for one cycle, aligned with the loaded outputs.
  - commit_count increments and wraps at 16 bits (65535 -> 0).
- Control write in mode 0: no effect.
- Control read returns {16'h0, commit_count}.
- Reserved index: a write is ignored, a read returns 0, and the ack is still issued.
- Out-of-range address: no ack, no state change.
- OPB_RNW and BE are sampled in IDLE on the hit edge; changes during ACK are ignored.

Test Plan:
1. Reset: assert OPB_Rst mid-ACK -> Sl_xferAck drops at once; all user_data_out = C_RESET_VALUE; user_update=0.
2. Mode 1, C_NUM_REGS=4:
   - Write 0xDEADBEEF to 0x01000100 and 0x12345678 to 0x01000104 -> user_data_out unchanged.
   - Readback returns the written values.
   - Write 1 to 0x01000110 -> both outputs update in the same cycle; user_update=4'b1111; user_commit one pulse; control read = 1.
3. Byte enables: reg0 = 0x00000000; write 0xAABBCCDD with BE=4'b0101 -> reg0 reads 0x00BB00DD.
4. Mode 0: write 0xCAFEF00D to 0x01000108 -> user_data_out[95:64] = 0xCAFEF00D at the ack cycle; user_update=4'b0100 for 1 cycle.
5. Boundaries:
   - Read at 0x01000114 (reserved) -> ack, data 0.
   - Access at 0x01000200 -> no ack.
   - 65536 commits -> count wraps to 0.
6. Back-to-back: hold select across 3 reads -> acks on alternate cycles, each carrying the correct data; Sl_DBus = 0 between acks.
